mem_arbiter: RTL

Single-port memory arbiter sharing one unified 16-bit memory between the fetch stage (instruction reads) and the memory stage (data reads and writes). It sits between both pipeline stages and the memory macro. It grants one outstanding transaction at a time, drives the memory request for one cycle, and routes the completion back to its owner. Data accesses have priority; an optional starvation guard prevents fetch lockout.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_starve_cnt.sv | 33 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encodings, owner codes and default starvation limit for mem_arbiter
package mem_arbiter_pkg;

  // Arbiter FSM states, 3-bit encoded
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } state_e;

  // Owner of the granted transaction
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Default number of consecutive data grants tolerated while fetch waits
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// mem_arbiter_starve_cnt: saturating data-grant counter for the fetch starvation guard (built only with MEM_ARBITER_STARVE_GUARD_EN)
`ifdef MEM_ARBITER_STARVE_GUARD_EN
module mem_arbiter_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at the limit
  always_comb begin
    cnt_d = clr ? 4'd0 : (inc && cnt_q != LIM) ? cnt_q + 4'd1 : cnt_q;
  end

  // Count register, cleared by asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 4'd0;
    else      cnt_q <= cnt_d;
  end

  assign hit = (cnt_q == LIM);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch and data stages; MEM_ARBITER_STARVE_GUARD_EN adds a fetch starvation guard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        req_q, req_d;
  logic        if_pend;
  logic        force_f;
  logic        gnt_d;
  logic        gnt_f;
  logic        idle;
  owner_e      own;

  assign idle    = (state_q == IDLE);
  assign if_pend = if_req & ~halt;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic hit;

  mem_arbiter_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk(clk),
    .rst(rst),
    .inc(idle & gnt_d & if_pend),
    .clr(idle & gnt_f),
    .hit(hit)
  );

  assign force_f = hit & if_pend;
`else
  // Strict data priority; the limit is kept only so both builds share one interface
  assign force_f = 1'b0 & (STARVE_LIMIT != 0);
`endif

  assign gnt_d = dm_req & ~force_f;
  assign gnt_f = if_pend & ~gnt_d;
  assign own   = gnt_d ? OWN_D : OWN_I;

  // Next-state logic: grant in IDLE, strobe for one cycle, wait for memory completion
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    req_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_d || gnt_f) begin
          state_d = (own == OWN_D) ? REQ_D : REQ_I;
          addr_d  = (own == OWN_D) ? dm_addr : if_addr;
          wr_d    = (own == OWN_D) & dm_wr;
          wdata_d = (own == OWN_D) ? dm_wdata : 16'h0000;
          req_d   = 1'b1;
        end
      end
      REQ_I:          state_d = WAIT_I;
      REQ_D:          state_d = WAIT_D;
      WAIT_I, WAIT_D: state_d = mem_done ? IDLE : state_q;
      default:        state_d = IDLE;
    endcase
  end

  // State and memory-side registers; a reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      wr_q    <= 1'b0;
      wdata_q <= 16'h0000;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_done  = mem_done & (state_q == WAIT_I);
  assign dm_done  = mem_done & (state_q == WAIT_D);
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign if_stall = if_req & ~if_done & ~halt;
  assign dm_stall = dm_req & ~dm_done;

endmodule
